// File: rtl/uart_status_reporter_pkg.sv
// Shared definitions for the UART status reporter.
//   tx_state_e    : byte transmitter sequencing states
//   FRAME_BYTES   : bytes per status frame
//   DEFAULT_HEADER: default first byte of a frame
//   cnt_width()   : counter width able to hold 0 .. max_count-1 (never below 1)
package uart_status_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } tx_state_e;

   localparam int unsigned FRAME_BYTES    = 4;
   localparam logic [7:0]  DEFAULT_HEADER = 8'hA5;

   function automatic int unsigned cnt_width(input int unsigned max_count);
      return (max_count > 1) ? int'($clog2(max_count)) : 1;
   endfunction

endpackage

// File: rtl/uart_status_reporter_if.sv
// Byte-load handshake between the frame sequencer and the byte transmitter.
//   start : one-cycle load strobe; data is sampled with it
//   data  : byte to send, LSB first
//   done  : high during the last cycle of the stop bit; a start in that
//           same cycle chains the next byte with no idle gap
interface uart_status_reporter_if;
   logic       start;
   logic [7:0] data;
   logic       done;

   modport master (output start, output data, input done);
   modport slave  (input start, input data, output done);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: bit timer, shift register and START/DATA/STOP
// sequencing.
//   clock_i, reset_n_i : clock, asynchronous active-low reset
//   byte_if            : slave side of the byte-load handshake
//   tx_o               : UART line, idle high
//   busy_o             : high whenever a byte is on the line
module uart_tx_byte
   import uart_status_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 104
) (
   input  logic                         clock_i,
   input  logic                         reset_n_i,
   uart_status_reporter_if.slave        byte_if,
   output logic                         tx_o,
   output logic                         busy_o
);

   localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
   typedef logic [CW-1:0] cnt_t;
   localparam cnt_t BitLast = cnt_t'(CLKS_PER_BIT - 1);

   tx_state_e  state_q, state_d;
   cnt_t       cnt_q, cnt_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [7:0] shift_q, shift_d;
   logic       tx_q, tx_d;
   logic       bit_end;
   logic       done;

   assign bit_end      = (cnt_q == BitLast);
   assign byte_if.done = done;
   assign tx_o         = tx_q;
   assign busy_o       = (state_q != StIdle);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + cnt_t'(1);
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      done      = 1'b0;
      case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (byte_if.start) begin
               state_d = StStart;
               shift_d = byte_if.data;
               tx_d    = 1'b0;
            end
         end
         StStart: begin
            if (bit_end) begin
               cnt_d     = '0;
               state_d   = StData;
               bit_idx_d = '0;
               tx_d      = shift_q[0];
               shift_d   = {1'b0, shift_q[7:1]};
            end
         end
         StData: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shift_q[0];
                  shift_d   = {1'b0, shift_q[7:1]};
               end
            end
         end
         StStop: begin
            if (bit_end) begin
               done  = 1'b1;
               cnt_d = '0;
               // Chain straight into the next start bit when the sequencer reloads now.
               if (byte_if.start) begin
                  state_d = StStart;
                  shift_d = byte_if.data;
                  tx_d    = 1'b0;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
      end
   end

endmodule

// File: rtl/uart_status_reporter.sv
// Status report scheduler owning the UART transmit line. Requests come from
// trigger_i, a periodic timer and (optionally) channel changes; each report
// snapshots the inputs and sends {HEADER, channels, ones, xor-checksum}, 8N1.
//   clock_i, reset_n_i : clock, asynchronous active-low reset
//   enable_i           : allows periodic and change-based requests
//   trigger_i          : one-cycle on-demand request, honoured regardless of enable_i
//   channels_i, ones_i : status to report
//   tx_o               : UART line, idle high
//   busy_o             : frame in flight
//   frame_done_o       : one-cycle pulse as the sequencer returns to idle
module uart_status_reporter
   import uart_status_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT     = 104,
   parameter int unsigned REPORT_PERIOD    = 100000,
   parameter bit          REPORT_ON_CHANGE = 1'b1,
   parameter logic [7:0]  HEADER_BYTE      = DEFAULT_HEADER
) (
   input  logic       clock_i,
   input  logic       reset_n_i,
   input  logic       enable_i,
   input  logic       trigger_i,
   input  logic [7:0] channels_i,
   input  logic [3:0] ones_i,
   output logic       tx_o,
   output logic       busy_o,
   output logic       frame_done_o
);

   localparam int unsigned PW = cnt_width(REPORT_PERIOD);
   typedef logic [PW-1:0] period_t;
   localparam period_t    PeriodLast = period_t'(REPORT_PERIOD - 1);
   localparam logic [1:0] LastByte   = 2'(FRAME_BYTES - 1);

   uart_status_reporter_if byte_if ();

   period_t    period_q, period_d;
   logic [7:0] channels_q;
   logic       pending_q, pending_d;
   logic [1:0] byte_idx_q, byte_idx_d;
   logic [7:0] snap_ch_q, snap_ch_d;
   logic [3:0] snap_ones_q, snap_ones_d;
   logic       frame_done_q, frame_done_d;

   logic       tx_busy;
   logic       period_tick, change_req, new_req;
   logic       start_load;
   logic [1:0] byte_sel;
   logic [7:0] load_data;

   assign period_tick = enable_i && (period_q == PeriodLast);
   assign change_req  = REPORT_ON_CHANGE && enable_i && (channels_i != channels_q);
   assign new_req     = trigger_i | period_tick | change_req;

   always_comb begin
      period_d = '0;
      if (enable_i && !period_tick) begin
         period_d = period_q + period_t'(1);
      end
   end

   // Frame sequencing: start from idle, then reload the transmitter on each
   // byte's final stop-bit cycle so bytes run back-to-back.
   always_comb begin
      pending_d    = pending_q | new_req;
      byte_idx_d   = byte_idx_q;
      snap_ch_d    = snap_ch_q;
      snap_ones_d  = snap_ones_q;
      frame_done_d = 1'b0;
      start_load   = 1'b0;
      byte_sel     = byte_idx_q;
      if (!tx_busy && (pending_q || new_req)) begin
         start_load  = 1'b1;
         pending_d   = 1'b0;
         byte_idx_d  = '0;
         byte_sel    = '0;
         snap_ch_d   = channels_i;
         snap_ones_d = ones_i;
      end else if (byte_if.done) begin
         if (byte_idx_q != LastByte) begin
            start_load = 1'b1;
            byte_idx_d = byte_idx_q + 2'd1;
            byte_sel   = byte_idx_q + 2'd1;
         end else begin
            frame_done_d = 1'b1;
         end
      end
   end

   always_comb begin
      load_data = '0;
      case (byte_sel)
         2'd0:    load_data = HEADER_BYTE;
         2'd1:    load_data = snap_ch_q;
         2'd2:    load_data = {4'h0, snap_ones_q};
         default: load_data = HEADER_BYTE ^ snap_ch_q ^ {4'h0, snap_ones_q};
      endcase
   end

   assign byte_if.start = start_load;
   assign byte_if.data  = load_data;
   assign busy_o        = tx_busy;
   assign frame_done_o  = frame_done_q;

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx_byte (
      .clock_i  (clock_i),
      .reset_n_i(reset_n_i),
      .byte_if  (byte_if),
      .tx_o     (tx_o),
      .busy_o   (tx_busy)
   );

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         period_q     <= '0;
         channels_q   <= '0;
         pending_q    <= 1'b0;
         byte_idx_q   <= '0;
         snap_ch_q    <= '0;
         snap_ones_q  <= '0;
         frame_done_q <= 1'b0;
      end else begin
         period_q     <= period_d;
         channels_q   <= channels_i;
         pending_q    <= pending_d;
         byte_idx_q   <= byte_idx_d;
         snap_ch_q    <= snap_ch_d;
         snap_ones_q  <= snap_ones_d;
         frame_done_q <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_uart_status_reporter.sv
// Scoreboard bench: stimulus pushes hand-computed frames, a UART monitor
// decodes tx_o and pops/compares each completed frame.
module tb_uart_status_reporter;

   localparam int unsigned CPB    = 4;
   localparam int unsigned PERIOD = 400;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       enable   = 1'b0;
   logic       trigger  = 1'b0;
   logic [7:0] channels = 8'h00;
   logic [3:0] ones     = 4'h0;
   logic       tx0, busy0, fd0, tx1, busy1, fd1;
   logic       sel      = 1'b0;
   logic       mon_tx, mon_busy, mon_fd;

   int unsigned cyc         = 0;
   int          n_checks    = 0;
   int          n_errors    = 0;
   int          frames_seen = 0;
   int          fd_count    = 0;
   int          load_cnt    = 0;
   int          done_cnt    = 0;
   logic [7:0]  last_load   = 8'h00;
   logic        mon_active  = 1'b0;
   logic        mon_abort   = 1'b0;

   typedef struct packed {
      logic [31:0] bytes;
      logic [31:0] start;
   } frame_t;
   frame_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign mon_tx   = sel ? tx1 : tx0;
   assign mon_busy = sel ? busy1 : busy0;
   assign mon_fd   = sel ? fd1 : fd0;

   uart_status_reporter #(
      .CLKS_PER_BIT(CPB), .REPORT_PERIOD(PERIOD), .REPORT_ON_CHANGE(1'b0), .HEADER_BYTE(8'hA5)
   ) dut (
      .clock_i(clk), .reset_n_i(rst_n), .enable_i(enable), .trigger_i(trigger),
      .channels_i(channels), .ones_i(ones), .tx_o(tx0), .busy_o(busy0), .frame_done_o(fd0)
   );

   uart_status_reporter #(
      .CLKS_PER_BIT(CPB), .REPORT_PERIOD(PERIOD), .REPORT_ON_CHANGE(1'b1), .HEADER_BYTE(8'hA5)
   ) dut_chg (
      .clock_i(clk), .reset_n_i(rst_n), .enable_i(enable), .trigger_i(trigger),
      .channels_i(channels), .ones_i(ones), .tx_o(tx1), .busy_o(busy1), .frame_done_o(fd1)
   );

   // Tap on the main DUT's internal byte handshake.
   uart_status_reporter_if tap_if ();
   assign tap_if.start = dut.byte_if.start;
   assign tap_if.data  = dut.byte_if.data;
   assign tap_if.done  = dut.byte_if.done;

   always @(posedge clk) begin
      if (tap_if.start) begin
         load_cnt  <= load_cnt + 1;
         last_load <= tap_if.data;
      end
      if (tap_if.done) done_cnt <= done_cnt + 1;
   end

   always @(negedge clk) if (rst_n && mon_fd) fd_count <= fd_count + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int unsigned c);
      while (cyc < c) tick(1);
   endtask

   task automatic pulse_trigger();
      trigger = 1'b1;
      tick(1);
      trigger = 1'b0;
   endtask

   task automatic push(input logic [31:0] bytes, input int unsigned start);
      frame_t f;
      f.bytes = bytes;
      f.start = start;
      exp_q.push_back(f);
   endtask

   task automatic wait_idle(input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         if (exp_q.size() == 0 && !mon_active) break;
         tick(1);
      end
      check("wait_idle_in_budget", 32'(k < budget), 32'd1);
   endtask

   task automatic mon_wait(input int n);
      for (int k = 0; k < n; k++) begin
         if (mon_abort) return;
         @(negedge clk);
         if (!rst_n) mon_abort = 1'b1;
      end
   endtask

   initial begin : monitor
      int unsigned s;
      logic [31:0] got;
      logic [7:0]  b;
      frame_t      e;
      b = '0;
      forever begin
         @(negedge clk);
         if (rst_n && mon_tx == 1'b0) begin
            s          = cyc;
            got        = '0;
            mon_abort  = 1'b0;
            mon_active = 1'b1;
            check("busy_at_start", 32'(mon_busy), 32'd1);
            for (int j = 0; j < 4; j++) begin
               mon_wait(2);
               if (!mon_abort) check("start_bit", 32'(mon_tx), 32'd0);
               for (int i = 0; i < 8; i++) begin
                  mon_wait(4);
                  b[i] = mon_tx;
               end
               mon_wait(4);
               if (!mon_abort) check("stop_bit", 32'(mon_tx), 32'd1);
               mon_wait(2);
               got = {got[23:0], b};
            end
            if (!mon_abort) begin
               check("frame_done_timing", 32'(mon_fd), 32'd1);
               check("busy_after_frame", 32'(mon_busy), 32'd0);
               frames_seen++;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_frame: got 0x%08h at cycle %0d, required none", got, s);
               end else begin
                  e = exp_q.pop_front();
                  check("frame_bytes", got, e.bytes);
                  check("frame_start_cycle", s, e.start);
               end
            end
            mon_active = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #(10 * 50000);
      $display("FAIL watchdog: simulation exceeded 50000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int unsigned t;
      int unsigned e;
      int          bad;
      int          l0, d0;

      // Reset state
      tick(3);
      check("reset_tx0", 32'(tx0), 32'd1);
      check("reset_busy0", 32'(busy0), 32'd0);
      check("reset_fd0", 32'(fd0), 32'd0);
      check("reset_tx1", 32'(tx1), 32'd1);

      // 1: idle with enable low
      rst_n = 1'b1;
      bad   = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
      end
      tick(1);
      check("idle_bad_cycles", 32'(bad), 32'd0);

      // 2: single trigger
      channels = 8'b1010_0011;
      ones     = 4'd4;
      tick(1);
      l0 = load_cnt;
      d0 = done_cnt;
      t  = cyc;
      push(32'hA5A3_0402, t + 1);
      pulse_trigger();
      check("trigger_latency_tx", 32'(tx0), 32'd0);
      wait_idle(400);
      check("byte_loads", 32'(load_cnt - l0), 32'd4);
      check("byte_dones", 32'(done_cnt - d0), 32'd4);
      check("last_load_checksum", 32'(last_load), 32'h02);

      // 3: periodic reports
      channels = 8'h3C;
      ones     = 4'd4;
      tick(2);
      enable = 1'b1;
      e      = cyc;
      for (int k = 1; k <= 5; k++) push(32'hA53C_049D, e + PERIOD * k);
      wait_until(e + 2010);
      enable = 1'b0;
      wait_idle(400);

      // 4: triggers and input change mid-frame
      channels = 8'h5A;
      ones     = 4'd4;
      tick(2);
      t = cyc;
      push(32'hA55A_04FB, t + 1);
      push(32'hA5FF_0852, t + 1 + 40 * CPB + 1);
      pulse_trigger();
      wait_until(t + 30);
      pulse_trigger();
      wait_until(t + 50);
      channels = 8'hFF;
      ones     = 4'd8;
      wait_until(t + 60);
      pulse_trigger();
      wait_until(t + 101);
      pulse_trigger();
      wait_idle(600);
      tick(300);

      // 5: change-triggered report on the REPORT_ON_CHANGE instance
      rst_n = 1'b0;
      tick(1);
      sel = 1'b1;
      tick(1);
      channels = 8'h10;
      ones     = 4'd1;
      rst_n    = 1'b1;
      tick(10);
      enable = 1'b1;
      e      = cyc;
      push(32'hA511_02B6, e + 51);
      push(32'hA511_02B6, e + PERIOD);
      wait_until(e + 50);
      channels = 8'h11;
      ones     = 4'd2;
      wait_until(e + 410);
      enable = 1'b0;
      wait_idle(400);

      // 6: reset mid-frame, then a clean frame
      rst_n = 1'b0;
      tick(1);
      sel = 1'b0;
      tick(1);
      rst_n    = 1'b1;
      channels = 8'hC3;
      ones     = 4'd4;
      tick(2);
      t = cyc;
      pulse_trigger();
      wait_until(t + 60);
      rst_n = 1'b0;
      #1;
      check("reset_midframe_tx", 32'(tx0), 32'd1);
      check("reset_midframe_busy", 32'(busy0), 32'd0);
      tick(3);
      rst_n    = 1'b1;
      channels = 8'h81;
      ones     = 4'd2;
      tick(2);
      t = cyc;
      push(32'hA581_0226, t + 1);
      pulse_trigger();
      wait_idle(400);
      tick(200);

      check("frames_total", 32'(frames_seen), 32'd11);
      check("frame_done_pulses", 32'(fd_count), 32'(frames_seen));
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_status_reporter.md
Name: uart_status_reporter

Overview:
Scheduler that owns the design's single UART transmit line and reports demodulator status over it.
- Sources for a report: a periodic timer, an on-demand trigger and (optionally) a change in the channel states.
- Each report snapshots the 8 PWM analyzer outputs and the ones count, then sends a fixed 4-byte frame, 8N1.
- Sits beside the ones counter; drives the UART transmit output pin.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit (1 MHz / 9600 baud); legal range >= 2.
- REPORT_PERIOD, 100000, clock cycles between periodic report requests; legal range >= 1.
- REPORT_ON_CHANGE, 1, 1 = any change of channels_i requests a report.
- HEADER_BYTE, 8'hA5, first byte of every frame.

Ports:
- clock_i  in  1  single system clock, rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  1 = periodic and change-based requests allowed.
- trigger_i  in  1  one-cycle on-demand report request; honoured even when enable_i = 0.
- channels_i  in  8  PWM analyzer outputs.
- ones_i  in  4  number of high channels (0..8).
- tx_o  out  1  UART line, idle high.
- busy_o  out  1  high while a frame is in flight.
- frame_done_o  out  1  one-cycle pulse after the last stop bit.

Behaviour:
- Reset (asynchronous, active-low) values:
  - tx_o = 1, busy_o = 0, frame_done_o = 0.
  - FSM = IDLE; period counter = 0; pending = 0; change register = 0.
- Request sources, each setting a one-deep pending flag; multiple requests merge into one:
  - trigger_i.
  - Period tick: counter reaches REPORT_PERIOD-1 while enable_i = 1, then wraps to 0. enable_i = 0 holds the counter at 0.
  - Change: REPORT_ON_CHANGE = 1, enable_i = 1, and channels_i differs from its registered copy of the previous cycle.
- FSM states: IDLE, START, DATA, STOP.
- IDLE with pending, or a request arriving this cycle:
  - Snapshot channels_i and ones_i.
  - Clear pending; byte index = 0.
  - Go to START. tx_o goes low on the next clock edge (1-cycle latency from request to start bit).
- Bit timing: each bit lasts exactly CLKS_PER_BIT cycles; data bits are sent LSB first.
  - START: tx_o = 0, then DATA.
  - DATA: 8 bits, then STOP.
  - STOP: tx_o = 1 for one bit time.
  - After STOP: if byte index < 3, increment it and go to START; else go to IDLE.
- Frame contents, in order:
  - byte0 = HEADER_BYTE
  - byte1 = channels snapshot
  - byte2 = {4'h0, ones snapshot}
  - byte3 = byte0 ^ byte1 ^ byte2
- Frame length: 40*CLKS_PER_BIT cycles. Frames sent back-to-back have no extra idle bits.
- busy_o is high from the cycle the start bit is driven through the last stop-bit cycle.
- frame_done_o pulses on the cycle the FSM returns to IDLE. If pending is set at that point, the next start bit follows on the next clock.
- Requests while busy set pending only; the frame in flight is never restarted or altered.
- Snapshot is frozen for the whole frame; input changes mid-frame are reported only through the change request path.
- enable_i falling mid-frame: the current frame completes; periodic and change requests stop; an already-set pending is still served.
- Reset mid-frame: tx_o returns high asynchronously and the frame is discarded. No partial resumption after reset.
- ones_i values above 8 are transmitted unchanged; no saturation.

Decomposition:
- Shared package uart_status_pkg:
  - State enum {IDLE, START, DATA, STOP}.
  - FRAME_BYTES = 4, DEFAULT_HEADER = 8'hA5.
  - Bit-counter width derived with $clog2(CLKS_PER_BIT).
- Sub-module uart_tx_byte:
  - Contains the bit timer, shift register and START/DATA/STOP sequencing.
  - Handshake: load byte on start_i; return done_o.
- The top level keeps: request sources, pending flag, snapshot, byte sequencing and checksum.

Test Plan:
All scenarios use CLKS_PER_BIT = 4, REPORT_PERIOD = 400, REPORT_ON_CHANGE = 0 unless stated.
1. Reset low, then high with enable_i = 0 and no trigger for 1000 cycles -> tx_o = 1, busy_o = 0 throughout.
2. channels_i = 8'b1010_0011, ones_i = 4, single trigger_i pulse:
   - tx_o low exactly 1 cycle later.
   - Decoded bytes A5, A3, 04, 02.
   - frame_done_o pulses 160 cycles after the start bit.
3. enable_i = 1, constant inputs for 2000 cycles -> start bits 400 cycles apart, 5 frames, each identical.
4. trigger_i pulsed 3 times during a frame; channels_i changed mid-frame to 8'hFF:
   - First frame still carries the original snapshot.
   - Exactly one follow-on frame starts 1 cycle after frame_done_o, with byte1 = FF.
5. REPORT_ON_CHANGE = 1, enable_i = 1, channels_i toggles bit0 once -> one frame reporting the new value; no further frames until the next period tick.
6. Reset asserted midway through byte1 -> tx_o = 1 immediately and busy_o = 0; after release a trigger produces a complete, correct 4-byte frame.
